mc_wb_queue: RTL and testbench
==============================

# mc_wb_queue

Write-back queue between the multi-cycle mod unit and the register file write port. Captures each result the mod unit signals with its write-enable pulse, together with the destination register, and holds it in a small FIFO. Drains one entry per cycle into the register file whenever the single-cycle pipeline is not writing, so a multi-cycle result never collides with a normal ALU write-back. Optionally flags read-after-write hazards against queued destinations.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥ 2
- DATA_W, 32, result width
- ADDR_W, 5, register address width
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Mc_We  in  1  push request; one-cycle pulse from mod unit write-enable
- Mc_Result  in  DATA_W  mod result to queue
- Mc_Dest  in  ADDR_W  destination register for Mc_Result
- Mc_Ready  out  1  queue not full
- Pipe_We  in  1  single-cycle pipeline owns the register file write port this cycle
- Rs_Addr  in  ADDR_W  decode-stage source register 1
- Rt_Addr  in  ADDR_W  decode-stage source register 2
- Rf_We  out  1  register file write enable
- Rf_Addr  out  ADDR_W  register file write address
- Rf_Data  out  DATA_W  register file write data
- Hazard  out  1  source register matches a queued destination
- Count  out  log2(DEPTH)+1  valid entries
- Overflow  out  1  sticky: a push was lost

## Operation
- Storage: DEPTH entries of {dest, data}; read and write pointers of log2(DEPTH) bits, wrap modulo DEPTH; Count tracks occupancy 0..DEPTH.
- Pop (drain): Rf_We = (Count != 0) & ~Pipe_We, combinational. Rf_Addr/Rf_Data = head entry at all times (don't-care when empty, driven from storage). Pop occurs at the edge where Rf_We = 1.
- Pipe_We = 1 always wins; queue holds, no entry lost.
- Push: Mc_We = 1 and Mc_Dest != 0 and (Count < DEPTH or pop this cycle) -> entry written at tail, tail advances.
- Mc_Dest = 0: push discarded silently (write to $zero); Count, Overflow unchanged.
- Push while full with no pop: discarded, Overflow set to 1, held until reset.
- Push and pop same edge: both happen, Count unchanged; permitted when full.
- Order strictly FIFO; two queued entries to the same register drain in order, later value lands last.
- Mc_Ready = (Count < DEPTH), combinational from Count.
- No state machine beyond pointers/count; no bypass from Mc_Result directly to Rf_Data (minimum one cycle in queue).

## Timing
- Reset low (async): pointers, Count = 0, Overflow = 0; therefore Rf_We = 0, Mc_Ready = 1, Hazard = 0 immediately. Storage contents not reset.
- Reset asserted mid-drain: all queued entries discarded; no write after reset release until a new push.
- Latency: push at edge N -> Rf_We earliest during cycle N (after edge N), written by register file at edge N+1.
- Throughput: one push and one pop per cycle.
- Hazard combinational from Rs_Addr, Rt_Addr, and valid entries (excluding the incoming push of the current cycle).

## Configuration
- WB_HAZARD_EN defined: Hazard = 1 when Rs_Addr or Rt_Addr is nonzero and equals the dest of any valid entry; comparators over all DEPTH entries.
- Not defined: no comparators; Hazard tied to 0; Rs_Addr, Rt_Addr unused.

## Test plan
- Reset: hold Reset = 0 -> Count = 0, Rf_We = 0, Mc_Ready = 1, Overflow = 0; release, idle 5 cycles -> Rf_We stays 0.
- Single push: Mc_We, Mc_Dest = 8, Mc_Result = 0x0000_0007, Pipe_We = 0 -> next cycle Rf_We = 1, Rf_Addr = 8, Rf_Data = 7; following cycle Count = 0.
- Pipe contention: push dest 3 / 0xAA, dest 4 / 0xBB, hold Pipe_We = 1 for 3 cycles -> Rf_We = 0, Count = 2; drop Pipe_We -> writes 3/0xAA then 4/0xBB on consecutive cycles.
- Full/overflow: Pipe_We = 1, push DEPTH+1 entries -> Mc_Ready = 0 after DEPTH, Overflow = 1, Count = DEPTH; drain writes exactly first DEPTH entries in order, pointers wrap correctly; then push + pop same edge at full keeps Count = DEPTH.
- $zero and reset mid-operation: push dest 0 -> Count unchanged; queue 2 entries, assert Reset mid-drain -> no further Rf_We, Count = 0.
- Hazard (WB_HAZARD_EN): queue dest 9, Rs_Addr = 9 -> Hazard = 1; Rt_Addr = 0 with dest-0 attempt -> Hazard = 0; after drain Hazard = 0; macro off -> Hazard = 0 throughout.

Source files
------------

// File: rtl/mc_wb_queue.sv
// mc_wb_queue: FIFO that holds mod-unit results and drains them into the
// register file write port on cycles the single-cycle pipeline leaves free.
// Ports: Clk/Reset (async, active-low); Mc_We/Mc_Result/Mc_Dest push side,
// Mc_Ready = not full; Pipe_We blocks the drain; Rf_We/Rf_Addr/Rf_Data drive
// the register file; Count = occupancy; Overflow = sticky lost push;
// Hazard flags Rs_Addr/Rt_Addr matching a queued dest (macro WB_HAZARD_EN,
// tied to 0 when the macro is undefined).
module mc_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mc_We,
    input  logic [DATA_W-1:0] Mc_Result,
    input  logic [ADDR_W-1:0] Mc_Dest,
    output logic              Mc_Ready,
    input  logic              Pipe_We,
    input  logic [ADDR_W-1:0] Rs_Addr,
    input  logic [ADDR_W-1:0] Rt_Addr,
    output logic              Rf_We,
    output logic [ADDR_W-1:0] Rf_Addr,
    output logic [DATA_W-1:0] Rf_Data,
    output logic              Hazard,
    output logic [CNT_W-1:0]  Count,
    output logic              Overflow
);

    logic [ADDR_W-1:0] mem_dest_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic full;
    logic pop;
    logic push_req;
    logic push;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop      = (count_q != '0) & ~Pipe_We;
    // Writes to $zero are dropped before they can occupy a slot.
    assign push_req = Mc_We & (Mc_Dest != '0);
    // A pop on the same edge frees the slot, so a full queue still accepts.
    assign push     = push_req & (~full | pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push_req & ~push) begin
            ovf_d = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately not reset; validity comes from the count.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_dest_q[wr_ptr_q] <= Mc_Dest;
            mem_data_q[wr_ptr_q] <= Mc_Result;
        end
    end

    assign Rf_We    = pop;
    assign Rf_Addr  = mem_dest_q[rd_ptr_q];
    assign Rf_Data  = mem_data_q[rd_ptr_q];
    assign Mc_Ready = ~full;
    assign Count    = count_q;
    assign Overflow = ovf_q;

`ifdef WB_HAZARD_EN
    // Distance of a slot from the head; slot is valid when below Count.
    function automatic logic [CNT_W-1:0] slot_ofs(
        input logic [PTR_W-1:0] idx,
        input logic [PTR_W-1:0] head
    );
        logic [PTR_W-1:0] d;
        d = idx - head;
        return {1'b0, d};
    endfunction

    logic [DEPTH-1:0] slot_vld;
    logic             haz;

    always_comb begin
        slot_vld = '0;
        haz      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_vld[i] = slot_ofs(PTR_W'(i), rd_ptr_q) < count_q;
            if (slot_vld[i]) begin
                if ((Rs_Addr != '0) && (mem_dest_q[i] == Rs_Addr)) begin
                    haz = 1'b1;
                end
                if ((Rt_Addr != '0) && (mem_dest_q[i] == Rt_Addr)) begin
                    haz = 1'b1;
                end
            end
        end
    end

    assign Hazard = haz;
`else
    logic unused_src;
    assign unused_src = ^{Rs_Addr, Rt_Addr};
    assign Hazard     = 1'b0;
`endif

endmodule

// File: tb/tb_mc_wb_queue.sv
// tb_mc_wb_queue: scoreboard bench for mc_wb_queue.
// A reference model predicts drains; every negedge compares DUT outputs.
module tb_mc_wb_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef WB_HAZARD_EN
    localparam bit HZ_EN = 1'b1;
`else
    localparam bit HZ_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              mc_we;
    logic [DATA_W-1:0] mc_result;
    logic [ADDR_W-1:0] mc_dest;
    logic              mc_ready;
    logic              pipe_we;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              hazard;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    mc_wb_queue #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .Mc_We    (mc_we),
        .Mc_Result(mc_result),
        .Mc_Dest  (mc_dest),
        .Mc_Ready (mc_ready),
        .Pipe_We  (pipe_we),
        .Rs_Addr  (rs_addr),
        .Rt_Addr  (rt_addr),
        .Rf_We    (rf_we),
        .Rf_Addr  (rf_addr),
        .Rf_Data  (rf_data),
        .Hazard   (hazard),
        .Count    (count),
        .Overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] d;
        logic [DATA_W-1:0] v;
    } ent_t;

    ent_t sb[$];
    bit   ovf_m;
    int   n_chk;
    int   n_pass;
    int   n_wr;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit model_haz();
        bit h;
        h = 1'b0;
        if (HZ_EN) begin
            foreach (sb[i]) begin
                if (rs_addr != 0 && sb[i].d == rs_addr) h = 1'b1;
                if (rt_addr != 0 && sb[i].d == rt_addr) h = 1'b1;
            end
        end
        return h;
    endfunction

    // Reference model: updates on the same edges as the DUT state.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            ovf_m = 1'b0;
        end else begin
            bit p_pop;
            bit p_acc;
            ent_t e;
            p_pop = (sb.size() != 0) && !pipe_we;
            p_acc = 1'b0;
            if (mc_we && mc_dest != 0) begin
                if (sb.size() < DEPTH || p_pop) p_acc = 1'b1;
                else ovf_m = 1'b1;
            end
            if (p_pop) void'(sb.pop_front());
            if (p_acc) begin
                e.d = mc_dest;
                e.v = mc_result;
                sb.push_back(e);
            end
        end
    end

    // Monitor: inputs are stable at the falling edge.
    always @(negedge clk) begin
        bit exp_we;
        exp_we = (sb.size() != 0) && !pipe_we;
        chk("rf_we", 64'(rf_we), 64'(exp_we));
        chk("count", 64'(count), 64'(sb.size()));
        chk("ready", 64'(mc_ready), 64'(sb.size() < DEPTH));
        chk("ovf", 64'(overflow), 64'(ovf_m));
        chk("hazard", 64'(hazard), 64'(model_haz()));
        if (exp_we) begin
            n_wr++;
            chk("rf_addr", 64'(rf_addr), 64'(sb[0].d));
            chk("rf_data", 64'(rf_data), 64'(sb[0].v));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push(input logic [ADDR_W-1:0] d,
                        input logic [DATA_W-1:0] v);
        mc_we     = 1'b1;
        mc_dest   = d;
        mc_result = v;
        cyc();
        mc_we     = 1'b0;
        mc_dest   = '0;
        mc_result = '0;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int wr0;
        n_chk     = 0;
        n_pass    = 0;
        n_wr      = 0;
        rst_n     = 1'b0;
        mc_we     = 1'b0;
        mc_result = '0;
        mc_dest   = '0;
        pipe_we   = 1'b0;
        rs_addr   = '0;
        rt_addr   = '0;

        // Reset state
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rfwe", 64'(rf_we), 64'd0);
        chk("rst_ready", 64'(mc_ready), 64'd1);
        chk("rst_ovf", 64'(overflow), 64'd0);
        idle(3);
        rst_n = 1'b1;
        wr0 = n_wr;
        idle(5);
        chk("idle_nowr", 64'(n_wr - wr0), 64'd0);

        // Single push, one cycle in queue
        push(5'd8, 32'h0000_0007);
        at_neg();
        chk("sp_we", 64'(rf_we), 64'd1);
        chk("sp_addr", 64'(rf_addr), 64'd8);
        chk("sp_data", 64'(rf_data), 64'd7);
        cyc();
        chk("sp_cnt", 64'(count), 64'd0);

        // Pipeline owns the write port
        pipe_we = 1'b1;
        push(5'd3, 32'hAA);
        push(5'd4, 32'hBB);
        idle(3);
        chk("pc_cnt", 64'(count), 64'd2);
        chk("pc_we", 64'(rf_we), 64'd0);
        pipe_we = 1'b0;
        #1;
        chk("pc_a0", 64'(rf_addr), 64'd3);
        chk("pc_d0", 64'(rf_data), 64'hAA);
        cyc();
        chk("pc_a1", 64'(rf_addr), 64'd4);
        chk("pc_d1", 64'(rf_data), 64'hBB);
        idle(3);

        // Fill past full with the port blocked
        pipe_we = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            push(5'(10 + i), 32'h100 + 32'(i));
        end
        chk("ful_ready", 64'(mc_ready), 64'd0);
        chk("ful_ovf", 64'(overflow), 64'd1);
        chk("ful_cnt", 64'(count), 64'(DEPTH));
        // Push and pop on the same edge while full
        pipe_we = 1'b0;
        push(5'd20, 32'h200);
        chk("pp_cnt", 64'(count), 64'(DEPTH));
        wr0 = n_wr;
        idle(DEPTH + 3);
        chk("drain_n", 64'(n_wr - wr0), 64'(DEPTH));
        chk("drain_cnt", 64'(count), 64'd0);

        // $zero destination is dropped
        push(5'd0, 32'hDEAD);
        chk("zero_cnt", 64'(count), 64'd0);
        chk("zero_ovf", 64'(overflow), 64'd1);

        // Reset during drain
        pipe_we = 1'b1;
        push(5'd6, 32'h66);
        push(5'd7, 32'h77);
        pipe_we = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mr_we", 64'(rf_we), 64'd0);
        chk("mr_cnt", 64'(count), 64'd0);
        chk("mr_ovf", 64'(overflow), 64'd0);
        idle(2);
        rst_n = 1'b1;
        wr0 = n_wr;
        idle(4);
        chk("mr_nowr", 64'(n_wr - wr0), 64'd0);

        // Hazard against queued destinations
        pipe_we = 1'b1;
        push(5'd9, 32'h99);
        rs_addr = 5'd9;
        #1;
        chk("hz_rs", 64'(hazard), 64'(HZ_EN));
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        mc_we   = 1'b1;
        mc_dest = 5'd0;
        #1;
        chk("hz_zero", 64'(hazard), 64'd0);
        cyc();
        mc_we   = 1'b0;
        rt_addr = 5'd9;
        #1;
        chk("hz_rt", 64'(hazard), 64'(HZ_EN));
        pipe_we = 1'b0;
        idle(2);
        chk("hz_drain", 64'(hazard), 64'd0);
        rt_addr = 5'd0;

        // Random traffic with small dest range to repeat registers
        for (int i = 0; i < 300; i++) begin
            mc_we     = 1'($urandom_range(0, 1));
            mc_dest   = 5'($urandom_range(0, 5));
            mc_result = $urandom;
            pipe_we   = ($urandom_range(0, 2) == 0);
            rs_addr   = 5'($urandom_range(0, 6));
            rt_addr   = 5'($urandom_range(0, 6));
            cyc();
        end
        mc_we   = 1'b0;
        pipe_we = 1'b0;
        idle(DEPTH + 2);
        chk("end_cnt", 64'(count), 64'd0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
